// File: rtl/fme_ip_ctrl.sv
// Sequencing controller for the FME interpolation datapath: fetches reference rows,
// steps the horizontal/vertical filter arrays and emits output-row strobes.
// Optional abort input is enabled by defining FME_IP_CTRL_ABORT_EN.
module fme_ip_ctrl #(
  parameter int BLK_SIZE = 8,
  parameter int ROW_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
`ifdef FME_IP_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic [1:0]       frac_x_i,
  input  logic [1:0]       frac_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ref_req_o,
  output logic [ROW_W-1:0] ref_row_o,
  input  logic             ref_gnt_i,
  output logic             hor_en_o,
  output logic [1:0]       hor_type_o,
  output logic             hor_byp_o,
  output logic             ver_shift_o,
  output logic [1:0]       ver_type_o,
  output logic             ver_byp_o,
  output logic             out_valid_o,
  output logic [ROW_W-1:0] out_row_o,
  input  logic             out_ready_i
);

  localparam logic [ROW_W-1:0] ROWS_FULL = ROW_W'(BLK_SIZE + 7);
  localparam logic [ROW_W-1:0] ROWS_BYP  = ROW_W'(BLK_SIZE);
  localparam logic [ROW_W-1:0] LAST_OUT  = ROW_W'(BLK_SIZE - 1);
  localparam logic [ROW_W-1:0] TAP_LAG   = ROW_W'(7);
  localparam logic [ROW_W-1:0] BYP_OFS   = ROW_W'(3);
  localparam logic [ROW_W-1:0] ONE       = ROW_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ROW_W-1:0] req_cnt;
  logic [ROW_W-1:0] hor_cnt;
  logic [ROW_W-1:0] rows_total;
  logic [ROW_W-1:0] row_base;
  logic             hor_en_q;
  logic             out_valid_q;
  logic [ROW_W-1:0] out_row_q;
  logic [1:0]       hor_type_q;
  logic [1:0]       ver_type_q;
  logic             hor_byp_q;
  logic             ver_byp_q;
  logic             ref_req;
  logic             grant;
  logic             last_req;
  logic             done_pulse;
  logic             abort_act;

  // Quarter-pel phase to filter selection; phase 0 bypasses and reports type 0.
  function automatic logic [1:0] phase_type(input logic [1:0] frac);
    logic [1:0] t;
    case (frac)
      2'd1:    t = 2'd1;
      2'd3:    t = 2'd2;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

`ifdef FME_IP_CTRL_ABORT_EN
  assign abort_act = abort_i && (state != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // Integer-phase vertical blocks skip the filter margin rows entirely.
  assign rows_total = ver_byp_q ? ROWS_BYP : ROWS_FULL;
  assign row_base   = ver_byp_q ? BYP_OFS : '0;
  assign last_req   = (req_cnt == (rows_total - ONE));
  assign grant      = ref_req && ref_gnt_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ref_req    = 1'b0;
    done_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        ref_req = out_ready_i;
        if (ref_req && ref_gnt_i && last_req) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid_q && (out_row_q == LAST_OUT)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done_pulse = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort_act) begin
      next_state = IDLE;
      ref_req    = 1'b0;
      done_pulse = 1'b0;
    end
  end

  // Filter selection is captured once per block and held until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hor_type_q <= 2'd0;
      ver_type_q <= 2'd0;
      hor_byp_q  <= 1'b0;
      ver_byp_q  <= 1'b0;
    end else if (state == IDLE && start_i) begin
      hor_type_q <= phase_type(frac_x_i);
      ver_type_q <= phase_type(frac_y_i);
      hor_byp_q  <= (frac_x_i == 2'd0);
      ver_byp_q  <= (frac_y_i == 2'd0);
    end
  end

  // Row pipeline: grant -> horizontal filter -> vertical window output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt     <= '0;
      hor_cnt     <= '0;
      hor_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else if (abort_act || (state == IDLE && start_i)) begin
      req_cnt     <= '0;
      hor_cnt     <= '0;
      hor_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      if (grant && (req_cnt != rows_total)) begin
        req_cnt <= req_cnt + ONE;
      end
      hor_en_q <= grant;
      if (hor_en_q && (hor_cnt != rows_total)) begin
        hor_cnt <= hor_cnt + ONE;
      end
      out_valid_q <= hor_en_q && (ver_byp_q || (hor_cnt >= TAP_LAG));
      if (hor_en_q) begin
        out_row_q <= ver_byp_q ? hor_cnt : (hor_cnt - TAP_LAG);
      end
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = done_pulse;
  assign ref_req_o   = ref_req;
  assign ref_row_o   = (state == FETCH) ? (row_base + req_cnt) : '0;
  assign hor_en_o    = hor_en_q && !abort_act;
  assign ver_shift_o = hor_en_q && !abort_act;
  assign out_valid_o = out_valid_q && !abort_act;
  assign out_row_o   = out_row_q;
  assign hor_type_o  = hor_type_q;
  assign ver_type_o  = ver_type_q;
  assign hor_byp_o   = hor_byp_q;
  assign ver_byp_o   = ver_byp_q;

endmodule

// File: tb/tb_fme_ip_ctrl.sv
// Self-checking bench for fme_ip_ctrl: a per-block timeline model derived from the
// grant sequence predicts every strobe, row index and the completion cycle.
module tb_fme_ip_ctrl;

  localparam int BLK   = 8;
  localparam int ROW_W = 5;

  logic             clk;
  logic             rst;
  logic             start_i;
`ifdef FME_IP_CTRL_ABORT_EN
  logic             abort_i;
`endif
  logic [1:0]       frac_x_i;
  logic [1:0]       frac_y_i;
  logic             busy_o;
  logic             done_o;
  logic             ref_req_o;
  logic [ROW_W-1:0] ref_row_o;
  logic             ref_gnt_i;
  logic             hor_en_o;
  logic [1:0]       hor_type_o;
  logic             hor_byp_o;
  logic             ver_shift_o;
  logic [1:0]       ver_type_o;
  logic             ver_byp_o;
  logic             out_valid_o;
  logic [ROW_W-1:0] out_row_o;
  logic             out_ready_i;

  int errors = 0;
  int checks = 0;

  fme_ip_ctrl #(.BLK_SIZE(BLK), .ROW_W(ROW_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
`ifdef FME_IP_CTRL_ABORT_EN
    .abort_i    (abort_i),
`endif
    .frac_x_i   (frac_x_i),
    .frac_y_i   (frac_y_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ref_req_o  (ref_req_o),
    .ref_row_o  (ref_row_o),
    .ref_gnt_i  (ref_gnt_i),
    .hor_en_o   (hor_en_o),
    .hor_type_o (hor_type_o),
    .hor_byp_o  (hor_byp_o),
    .ver_shift_o(ver_shift_o),
    .ver_type_o (ver_type_o),
    .ver_byp_o  (ver_byp_o),
    .out_valid_o(out_valid_o),
    .out_row_o  (out_row_o),
    .out_ready_i(out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one block starting at relative cycle 0 (caller leaves the DUT idle, just after a
  // rising edge). gmode: 0 always grant, 1 grant on even cycles, 2 random.
  // rmode: 0 always ready, 1 ready low on cycles 5..9, 2 random. inj: random start_i mid-block.
  task automatic run_block(input int fx, input int fy, input int gmode, input int rmode,
                           input bit inj, output int done_at, output int n_valid,
                           output int stall_valid);
    int tmap[4] = '{0, 1, 0, 2};
    int n, base, granted, g1, g2, gnow, done_cyc, exp_orow, c;
    bit byp_y, rdy, gnt, exp_req, exp_hor, exp_ov, exp_done, exp_busy, finished;
    byp_y = (fy == 0);
    n = byp_y ? BLK : BLK + 7;
    base = byp_y ? 3 : 0;
    granted = 0; g1 = -1; g2 = -1; done_cyc = -1;
    done_at = -1; n_valid = 0; stall_valid = 0; finished = 0;
    frac_x_i = 2'(fx);
    frac_y_i = 2'(fy);
    for (c = 0; c < 300 && !finished; c++) begin
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = !(c >= 5 && c <= 9);
        default: rdy = ($urandom % 4) != 0;
      endcase
      case (gmode)
        0: gnt = 1'b1;
        1: gnt = (c % 2) == 0;
        default: gnt = 1'($urandom % 2);
      endcase
      out_ready_i = rdy;
      ref_gnt_i = gnt;
      if (c == 0) start_i = 1'b1;
      else if (inj && (done_cyc < 0 || c <= done_cyc)) start_i = 1'($urandom % 2);
      else start_i = 1'b0;

      exp_req  = (c >= 1) && (granted < n) && rdy;
      exp_hor  = (g1 >= 0);
      exp_ov   = (g2 >= 0) && (byp_y || g2 >= 7);
      exp_orow = byp_y ? g2 : g2 - 7;
      exp_done = (done_cyc == c);
      exp_busy = (c >= 1) && (done_cyc < 0 || c <= done_cyc);

      @(negedge clk);
      checks += 5;
      if (ref_req_o !== exp_req) begin
        errors++; $display("[TB] FAIL ref_req c=%0d got=%0b exp=%0b", c, ref_req_o, exp_req);
      end
      if (hor_en_o !== exp_hor) begin
        errors++; $display("[TB] FAIL hor_en c=%0d got=%0b exp=%0b", c, hor_en_o, exp_hor);
      end
      if (ver_shift_o !== exp_hor) begin
        errors++; $display("[TB] FAIL ver_shift c=%0d got=%0b exp=%0b", c, ver_shift_o, exp_hor);
      end
      if (out_valid_o !== exp_ov) begin
        errors++; $display("[TB] FAIL out_valid c=%0d got=%0b exp=%0b", c, out_valid_o, exp_ov);
      end
      if (done_o !== exp_done || busy_o !== exp_busy) begin
        errors++;
        $display("[TB] FAIL done/busy c=%0d got=%0b/%0b exp=%0b/%0b", c, done_o, busy_o,
                 exp_done, exp_busy);
      end
      if (exp_req) begin
        checks++;
        if (ref_row_o !== ROW_W'(base + granted)) begin
          errors++; $display("[TB] FAIL ref_row c=%0d got=%0d exp=%0d", c, ref_row_o, base + granted);
        end
      end
      if (exp_ov) begin
        checks++;
        if (out_row_o !== ROW_W'(exp_orow)) begin
          errors++; $display("[TB] FAIL out_row c=%0d got=%0d exp=%0d", c, out_row_o, exp_orow);
        end
      end
      if (c >= 1) begin
        checks++;
        if (hor_type_o !== 2'(tmap[fx]) || ver_type_o !== 2'(tmap[fy]) ||
            hor_byp_o !== (fx == 0) || ver_byp_o !== (fy == 0)) begin
          errors++;
          $display("[TB] FAIL type/byp c=%0d got=%0d/%0d/%0b/%0b exp=%0d/%0d/%0b/%0b", c,
                   hor_type_o, ver_type_o, hor_byp_o, ver_byp_o, tmap[fx], tmap[fy],
                   fx == 0, fy == 0);
        end
      end
      if (out_valid_o === 1'b1) begin
        n_valid++;
        if (c >= 5 && c <= 9) stall_valid++;
      end
      if (done_o === 1'b1 && done_at < 0) done_at = c;

      gnow = (exp_req && gnt) ? granted : -1;
      if (gnow >= 0) begin
        granted++;
        if (granted == n) done_cyc = c + 3;
      end
      g2 = g1;
      g1 = gnow;
      if (done_cyc >= 0 && c == done_cyc + 1) finished = 1'b1;

      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    if (!finished) begin
      errors++;
      checks++;
      $display("[TB] FAIL block_timeout got=%0d exp=%0d", granted, n);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || ref_req_o !== 1'b0 || ref_row_o !== '0 ||
        hor_en_o !== 1'b0 || ver_shift_o !== 1'b0 || out_valid_o !== 1'b0 ||
        out_row_o !== '0 || hor_type_o !== 2'd0 || ver_type_o !== 2'd0 ||
        hor_byp_o !== 1'b0 || ver_byp_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got=busy%0b req%0b row%0d ov%0b exp=all zero",
               busy_o, ref_req_o, ref_row_o, out_valid_o);
    end
  endtask

  task automatic test_nominal();
    int d, nv, sv;
    run_block(2, 1, 0, 0, 1'b0, d, nv, sv);
    checks += 2;
    if (d !== 18) begin
      errors++; $display("[TB] FAIL nominal_done_cycle got=%0d exp=%0d", d, 18);
    end
    if (nv !== BLK) begin
      errors++; $display("[TB] FAIL nominal_rows got=%0d exp=%0d", nv, BLK);
    end
  endtask

  task automatic test_bypass();
    int d, nv, sv;
    run_block(0, 0, 0, 0, 1'b0, d, nv, sv);
    checks++;
    if (d !== 11) begin
      errors++; $display("[TB] FAIL bypass_done_cycle got=%0d exp=%0d", d, 11);
    end
  endtask

  task automatic test_sparse_grant();
    int d, nv, sv;
    run_block(3, 3, 1, 0, 1'b0, d, nv, sv);
    checks++;
    if (d !== 33) begin
      errors++; $display("[TB] FAIL sparse_done_cycle got=%0d exp=%0d", d, 33);
    end
  endtask

  task automatic test_stall();
    int d, nv, sv;
    run_block(1, 2, 0, 1, 1'b0, d, nv, sv);
    checks += 2;
    if (sv > 2) begin
      errors++; $display("[TB] FAIL stall_inflight got=%0d exp<=%0d", sv, 2);
    end
    if (nv !== BLK) begin
      errors++; $display("[TB] FAIL stall_rows got=%0d exp=%0d", nv, BLK);
    end
  endtask

  task automatic test_reset_mid_block();
    int d, nv, sv;
    frac_x_i = 2'd3;
    frac_y_i = 2'd1;
    ref_gnt_i = 1'b1;
    out_ready_i = 1'b1;
    start_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ref_req_o !== 1'b0 || hor_en_o !== 1'b0 || out_valid_o !== 1'b0 ||
        hor_type_o !== 2'd0 || ver_type_o !== 2'd0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midblock_reset got=busy%0b req%0b hen%0b htype%0d exp=all zero",
               busy_o, ref_req_o, hor_en_o, hor_type_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_block(3, 1, 0, 0, 1'b0, d, nv, sv);
    checks++;
    if (d !== 18) begin
      errors++; $display("[TB] FAIL post_reset_done got=%0d exp=%0d", d, 18);
    end
  endtask

  task automatic test_random();
    int d, nv, sv;
    for (int i = 0; i < 12; i++) begin
      run_block(int'($urandom % 4), int'($urandom % 4), 2, 2, 1'b1, d, nv, sv);
      checks++;
      if (nv !== BLK) begin
        errors++; $display("[TB] FAIL random_rows blk=%0d got=%0d exp=%0d", i, nv, BLK);
      end
    end
  endtask

`ifdef FME_IP_CTRL_ABORT_EN
  task automatic test_abort();
    int d, nv, sv;
    frac_x_i = 2'd2;
    frac_y_i = 2'd1;
    ref_gnt_i = 1'b1;
    out_ready_i = 1'b1;
    start_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    abort_i = 1'b1;
    @(negedge clk);
    checks++;
    if (ref_req_o !== 1'b0 || hor_en_o !== 1'b0 || ver_shift_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_drop got=req%0b hen%0b exp=0", ref_req_o, hor_en_o);
    end
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_idle got=busy%0b done%0b exp=0", busy_o, done_o);
    end
    @(posedge clk);
    #1;
    run_block(2, 1, 0, 0, 1'b0, d, nv, sv);
    checks++;
    if (d !== 18) begin
      errors++; $display("[TB] FAIL post_abort_done got=%0d exp=%0d", d, 18);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    frac_x_i = 2'd0;
    frac_y_i = 2'd0;
    ref_gnt_i = 1'b0;
    out_ready_i = 1'b1;
`ifdef FME_IP_CTRL_ABORT_EN
    abort_i = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_nominal();
    test_bypass();
    test_sparse_grant();
    test_stall();
    test_reset_mid_block();
`ifdef FME_IP_CTRL_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
